mux_rr_reg: RTL and testbench

MUX_RR_REG -- requirements
Module: mux_rr_reg

---
 rtl/mux_rr_reg.sv | 85 ++++++++
 tb/tb_mux_rr_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_reg.sv
// Registered N:1 channel mux with fixed-select or round-robin arbitration and a
// one-word output slot. Optional `MUX_RR_REG_XFER_CNT_EN adds a saturating
// output-transfer counter port xfer_cnt.
module mux_rr_reg #(
  parameter int WIDTH = 5,
  parameter int SEL_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [(2**SEL_W)*WIDTH-1:0]  in_data,
  input  logic [(2**SEL_W)-1:0]        in_valid,
  output logic [(2**SEL_W)-1:0]        in_ready,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             sel,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SEL_W-1:0]             out_ch
`ifdef MUX_RR_REG_XFER_CNT_EN
  ,
  output logic [15:0]                  xfer_cnt
`endif
);

  localparam int CH = 2**SEL_W;

  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_hit;
  logic [SEL_W-1:0] grant;
  logic             grant_hit;
  logic             can_load;
  logic             in_xfer;

  // Search starts one past the last served channel; SEL_W-bit add wraps naturally.
  always_comb begin
    rr_hit   = 1'b0;
    rr_grant = last;
    rr_idx   = last;
    for (int k = 1; k <= CH; k++) begin
      rr_idx = last + SEL_W'(k);
      if (!rr_hit && in_valid[rr_idx]) begin
        rr_hit   = 1'b1;
        rr_grant = rr_idx;
      end
    end
  end

  always_comb begin
    grant     = mode ? rr_grant : sel;
    grant_hit = mode ? rr_hit : in_valid[sel];
  end

  assign can_load = !rst && (!out_valid || out_ready);
  assign in_xfer  = can_load && grant_hit;
  assign in_ready = in_xfer ? (CH'(1) << grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      last      <= SEL_W'(CH - 1);
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_ch    <= grant;
      last      <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_REG_XFER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF)) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg (WIDTH=5, SEL_W=2): directed vector table, hand sequences
// and randomized traffic checked against a queue-free behavioural model.
module tb_mux_rr_reg;

  localparam int W  = 5;
  localparam int SW = 2;
  localparam int CH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_ch;
`ifdef MUX_RR_REG_XFER_CNT_EN
  logic [15:0]     xfer_cnt;
`endif

  always #5 clk = ~clk;

  mux_rr_reg #(.WIDTH(W), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
`ifdef MUX_RR_REG_XFER_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_valid, m_data, m_ch, m_last, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns channel granted by the rules, or -1 when none.
  function automatic int model_grant();
    int g;
    g = -1;
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) begin
      if (in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 1; k <= CH; k++) begin
        if (g < 0 && in_valid[(m_last + k) % CH]) g = (m_last + k) % CH;
      end
    end
    return g;
  endfunction

  // Inputs must already be driven; checks in_ready, clocks once, checks outputs.
  task automatic step();
    int g;
    logic [CH-1:0] exp_rdy;
    #3;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (rst) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_last = CH - 1; m_cnt = 0;
    end else begin
      if (m_valid && out_ready && m_cnt < 16'hFFFF) m_cnt++;
      if (g >= 0) begin
        m_valid = 1; m_ch = g; m_last = g;
        m_data = int'((in_data >> (g * W)) & ((1 << W) - 1));
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_RR_REG_XFER_CNT_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic drive(input logic r, input logic md, input logic [SW-1:0] s,
                       input logic [CH-1:0] iv, input logic ordy);
    rst = r; mode = md; sel = s; in_valid = iv; out_ready = ordy;
  endtask

  typedef struct {
    logic          r;
    logic          md;
    logic [SW-1:0] s;
    logic [CH-1:0] iv;
    logic          ordy;
    logic [CH-1:0] e_rdy;
    logic          e_ov;
    logic [W-1:0]  e_od;
    logic [SW-1:0] e_och;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{1, 0, 0, 4'b0000, 1, 4'b0000, 0, 5'h00, 0};
    vecs[1]  = '{1, 0, 0, 4'b1111, 1, 4'b0000, 0, 5'h00, 0};
    vecs[2]  = '{0, 0, 0, 4'b0000, 1, 4'b0000, 0, 5'h00, 0};
    vecs[3]  = '{0, 0, 2, 4'b1111, 1, 4'b0100, 1, 5'h15, 2};
    vecs[4]  = '{0, 1, 0, 4'b1111, 1, 4'b1000, 1, 5'h1F, 3};
    vecs[5]  = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 5'h01, 0};
    vecs[6]  = '{0, 1, 0, 4'b1010, 1, 4'b0010, 1, 5'h0A, 1};
    vecs[7]  = '{0, 1, 0, 4'b1010, 1, 4'b1000, 1, 5'h1F, 3};
    vecs[8]  = '{0, 1, 0, 4'b1010, 1, 4'b0010, 1, 5'h0A, 1};
    vecs[9]  = '{0, 1, 0, 4'b1111, 0, 4'b0000, 1, 5'h0A, 1};
    vecs[10] = '{0, 1, 0, 4'b1111, 0, 4'b0000, 1, 5'h0A, 1};
    vecs[11] = '{0, 1, 0, 4'b1111, 0, 4'b0000, 1, 5'h0A, 1};
    vecs[12] = '{0, 1, 0, 4'b1111, 1, 4'b0100, 1, 5'h15, 2};
    vecs[13] = '{0, 1, 0, 4'b0000, 1, 4'b0000, 0, 5'h15, 2};
    vecs[14] = '{0, 1, 0, 4'b0000, 0, 4'b0000, 0, 5'h15, 2};
    vecs[15] = '{0, 0, 1, 4'b0101, 1, 4'b0000, 0, 5'h15, 2};
    vecs[16] = '{0, 0, 0, 4'b0101, 0, 4'b0001, 1, 5'h01, 0};
    vecs[17] = '{1, 0, 0, 4'b1111, 0, 4'b0000, 0, 5'h00, 0};
    vecs[18] = '{0, 1, 0, 4'b1111, 1, 4'b0001, 1, 5'h01, 0};

    m_valid = 0; m_data = 0; m_ch = 0; m_last = CH - 1; m_cnt = 0;
    in_data = {5'h1F, 5'h15, 5'h0A, 5'h01};
    drive(1, 0, 0, 4'b0000, 0);

    // Directed vector table
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].r, vecs[i].md, vecs[i].s, vecs[i].iv, vecs[i].ordy);
      #3;
      chk("vec_in_ready", 32'(in_ready), 32'(vecs[i].e_rdy));
      #(-0);
      begin
        int g;
        g = model_grant();
        if (rst) begin
          m_valid = 0; m_data = 0; m_ch = 0; m_last = CH - 1; m_cnt = 0;
        end else begin
          if (m_valid && out_ready && m_cnt < 16'hFFFF) m_cnt++;
          if (g >= 0) begin
            m_valid = 1; m_ch = g; m_last = g;
            m_data = int'((in_data >> (g * W)) & ((1 << W) - 1));
          end else if (m_valid && out_ready) m_valid = 0;
        end
      end
      @(posedge clk);
      #1;
      chk("vec_out_valid", 32'(out_valid), 32'(vecs[i].e_ov));
      chk("vec_out_data", 32'(out_data), 32'(vecs[i].e_od));
      chk("vec_out_ch", 32'(out_ch), 32'(vecs[i].e_och));
    end

    // Round-robin from reset with all channels valid: 0,1,2,3,0 back to back
    drive(1, 1, 0, 4'b1111, 1);
    step();
    step();
    drive(0, 1, 0, 4'b1111, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq_ch", 32'(out_ch), 32'(i % CH));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Backpressure hold then simultaneous drain and load
    drive(0, 1, 0, 4'b1111, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ch", 32'(out_ch), 32'd0);
    end
    drive(0, 1, 0, 4'b1111, 1);
    step();
    chk("bp_reload_ch", 32'(out_ch), 32'd1);
    chk("bp_reload_valid", 32'(out_valid), 32'd1);

`ifdef MUX_RR_REG_XFER_CNT_EN
    drive(1, 1, 0, 4'b1111, 1);
    step();
    drive(0, 1, 0, 4'b1111, 1);
    for (int i = 0; i < 6; i++) step();
    chk("cnt_five", 32'(xfer_cnt), 32'd5);
    for (int i = 0; i < 65540; i++) step();
    chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
    drive(1, 1, 0, 4'b1111, 1);
    step();
    chk("cnt_rst", 32'(xfer_cnt), 32'd0);
`endif

    // Randomized traffic against the model
    drive(1, 0, 0, 4'b0000, 0);
    step();
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom), SW'($urandom),
            CH'($urandom), ($urandom_range(0, 3) != 0));
      in_data = (CH*W)'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
